hpdcache_slot_allocator: RTL
============================

Name: hpdcache_slot_allocator

Overview:
- Tracks ownership of N identical resource slots (MSHR entries, refill buffers, write-buffer entries) with a registered busy bitmap.
- On each cycle it offers the lowest-index free slot to a requester over a valid/ready handshake.
- It frees slots on release requests, exposes occupancy status to the miss-handling and refill pipelines, and flags illegal releases.

Parameters:
- N, 8, number of slots; legal range 2..64.
- N_LOG2, $clog2(N), localparam; slot index width.
- CNT_W, $clog2(N+1), localparam; occupancy counter width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- alloc_valid_i  in  1  requester wants a slot this cycle.
- alloc_ready_o  out  1  a free slot is available; equals ~full_o & ~flush_i.
- alloc_id_o  out  N_LOG2  lowest-index free slot; valid only while alloc_ready_o=1, otherwise 0.
- release_valid_i  in  1  free the slot given by release_id_i.
- release_id_i  in  N_LOG2  index of the slot to free.
- flush_i  in  1  free all slots at the next edge.
- busy_o  out  N  registered busy bitmap.
- count_o  out  CNT_W  registered number of busy slots.
- empty_o  out  1  count_o==0.
- full_o  out  1  count_o==N.
- err_o  out  1  sticky illegal-release flag.

Behaviour:
- Reset (rst_i=1 at an edge): busy_o=0, count_o=0, empty_o=1, full_o=0, err_o=0. After reset, alloc_ready_o=1 and alloc_id_o=0. Reset has priority over every other input, including in-flight handshakes.
- Free-slot select (combinational from registered state): free = ~busy_o, then priority-encode free so the lowest set index wins. With N=4, free=4'b1010 gives alloc_id_o=1.
- Allocation fires when alloc_valid_i & alloc_ready_o are both 1:
  - busy_o[alloc_id_o] is set at the next edge.
  - The requester samples alloc_id_o in the same cycle as the handshake (zero-latency grant).
  - Only one allocation is possible per cycle.
- Release is legal when release_valid_i=1, release_id_i<N and busy_o[release_id_i]=1. busy_o[release_id_i] is cleared at the next edge.
- Illegal release (id>=N or slot already free):
  - no state change;
  - err_o is set at the next edge and stays set until reset.
- Simultaneous allocation and release:
  - Both apply at the same edge and count_o is unchanged.
  - The slot being released is not a candidate for alloc_id_o in that cycle, because selection uses the pre-edge bitmap. The grant therefore never aliases the release.
  - When full_o=1, alloc_ready_o=0 even if a release is present; the freed slot becomes allocatable the next cycle.
- Flush:
  - busy_o=0 and count_o=0 at the next edge.
  - alloc_ready_o is forced to 0 in the flush cycle.
  - A release in the same cycle is ignored and does not raise an error.
  - err_o is preserved.
- count_o: next value = count + fire_alloc - fire_release, computed at CNT_W width. It never wraps because the handshake rules keep it within 0..N.
- Invariant: count_o == popcount(busy_o) in every cycle. Verification checks this with an assertion.
- Assertion: alloc_valid_i must stay asserted until the handshake completes (no retraction while stalled).
- No combinational path from alloc_valid_i to alloc_ready_o or alloc_id_o.

Decomposition:
- No new package. Index and counter widths are derived locally.
- Free-slot selection instantiates the existing common priority binary encoder hpdcache_prio_bin_encoder (N=N) on ~busy_o. No other sub-module.
- The remaining logic is the bitmap register, counter and error flag, roughly 150 lines.

Test Plan:
- N=4, reset, then alloc_valid_i=1 for 4 cycles -> alloc_id_o 0,1,2,3; count_o 1,2,3,4; full_o=1 and alloc_ready_o=0 after the 4th edge.
- From full, release id 2 -> next cycle busy_o=4'b1011, alloc_id_o=2, count_o=3; an allocation then refills slot 2.
- busy_o=4'b0011, same-cycle allocation plus release id 0 -> grant id 2, next busy_o=4'b0110, count_o unchanged at 2.
- busy_o=4'b0101, release id 1 (free) -> busy_o unchanged, err_o=1 and stays 1 through further traffic until rst_i.
- Full, flush_i=1 with alloc_valid_i=1 and release id 3 -> alloc_ready_o=0 that cycle, next busy_o=0, count_o=0, empty_o=1, err_o unchanged.
- Random alloc/release/flush for 10k cycles at N=6 (id>=6 treated as illegal) -> popcount invariant holds, no duplicate grants, err_o is set only on illegal releases.

Source files
------------

// File: rtl/hpdcache_prio_bin_encoder.sv
// Priority binary encoder: returns the index of the lowest set bit of val_i.
// Purely combinational; returns 0 when no bit is set.
module hpdcache_prio_bin_encoder #(
    parameter int N = 8
) (
    input  logic [N-1:0]         val_i,
    output logic [$clog2(N)-1:0] val_o
);
    localparam int W = $clog2(N);

    // Scan from the top so the lowest set index is the last write and wins.
    always_comb begin
        val_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (val_i[i]) val_o = W'(i);
        end
    end
endmodule

// File: rtl/hpdcache_slot_allocator.sv
// Slot allocator: registered busy bitmap, zero-latency lowest-free grant over valid/ready.
// Grant and ready depend only on registered state and flush_i; ready drops when full or flushing.
module hpdcache_slot_allocator #(
    parameter  int N      = 8,
    localparam int N_LOG2 = $clog2(N),
    localparam int CNT_W  = $clog2(N + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              alloc_valid_i,
    output logic              alloc_ready_o,
    output logic [N_LOG2-1:0] alloc_id_o,
    input  logic              release_valid_i,
    input  logic [N_LOG2-1:0] release_id_i,
    input  logic              flush_i,
    output logic [N-1:0]      busy_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              err_o
);
    logic [N-1:0]      r_busy;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;

    logic [N_LOG2-1:0] w_free_id;
    logic              w_full;
    logic              w_alloc_fire;
    logic              w_rel_hit;
    logic              w_rel_fire;
    logic              w_rel_illegal;
    logic [N-1:0]      w_alloc_mask;
    logic [N-1:0]      w_rel_mask;
    logic [N-1:0]      w_busy_nxt;
    logic [CNT_W-1:0]  w_count_nxt;

    hpdcache_prio_bin_encoder #(
        .N (N)
    ) free_slot_enc_i (
        .val_i (~r_busy),
        .val_o (w_free_id)
    );

    assign w_full        = (r_count == CNT_W'(N));
    assign alloc_ready_o = ~w_full & ~flush_i;
    assign alloc_id_o    = alloc_ready_o ? w_free_id : '0;
    assign w_alloc_fire  = alloc_valid_i & alloc_ready_o;

    // Out-of-range ids never match any slot, so they read back as "not busy".
    always_comb begin
        w_rel_hit    = 1'b0;
        w_rel_mask   = '0;
        w_alloc_mask = '0;
        for (int i = 0; i < N; i++) begin
            if (release_id_i == N_LOG2'(i)) begin
                w_rel_hit     = r_busy[i];
                w_rel_mask[i] = 1'b1;
            end
            if (w_free_id == N_LOG2'(i)) w_alloc_mask[i] = w_alloc_fire;
        end
    end

    assign w_rel_fire    = release_valid_i & w_rel_hit & ~flush_i;
    assign w_rel_illegal = release_valid_i & ~w_rel_hit & ~flush_i;

    // The granted slot is free and the released one busy, so the masks never overlap.
    assign w_busy_nxt  = (r_busy & ~(w_rel_fire ? w_rel_mask : '0)) | w_alloc_mask;
    assign w_count_nxt = r_count + CNT_W'(w_alloc_fire) - CNT_W'(w_rel_fire);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_rel_illegal) begin
            r_err <= 1'b1;
        end
    end

    assign busy_o  = r_busy;
    assign count_o = r_count;
    assign empty_o = (r_count == '0);
    assign full_o  = w_full;
    assign err_o   = r_err;
endmodule
